// File: rtl/vga_score_pkg.sv
// vga_score_pkg: VGA timing, digit geometry, colours and digit helpers
package vga_score_pkg;
  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] H_FP = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP = 10'd48;
  localparam logic [9:0] H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END = H_SYNC_START + H_SYNC - 10'd1;
  localparam logic [9:0] V_VIS = 10'd480;
  localparam logic [9:0] V_FP = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP = 10'd33;
  localparam logic [9:0] V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END = V_SYNC_START + V_SYNC - 10'd1;
  localparam logic [9:0] BOX_W = 10'd64;
  localparam logic [9:0] BOX_H = 10'd128;
  localparam logic [9:0] TENS_X = 10'd256;
  localparam logic [9:0] ONES_X = 10'd336;
  localparam logic [9:0] BOX_Y = 10'd176;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h004;
  typedef struct packed {
    logic [5:0] x0;
    logic [5:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
  } rect_t;
  // box-local segment rectangles, index 0..6 = a..g
  localparam rect_t SEG_RECT [7] = '{
    '{6'd8, 6'd55, 7'd0, 7'd7},
    '{6'd56, 6'd63, 7'd8, 7'd59},
    '{6'd56, 6'd63, 7'd68, 7'd119},
    '{6'd8, 6'd55, 7'd120, 7'd127},
    '{6'd0, 6'd7, 7'd68, 7'd119},
    '{6'd0, 6'd7, 7'd8, 7'd59},
    '{6'd8, 6'd55, 7'd60, 7'd67}
  };
  // lit segments per digit, bit 0 = a .. bit 6 = g
  localparam logic [6:0] SEG_MAP [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  // tens digit of 0..99 by a compare chain, avoiding a divider
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    tens_of = 4'd0;
    for (int i = 1; i <= 9; i++) if (v >= 7'(10 * i)) tens_of = 4'(i);
  endfunction
endpackage

// File: rtl/vga_score_display_if.sv
// vga_score_display_if: score input and VGA output bundle
interface vga_score_display_if;
  logic [31:0] score;
  logic hSync;
  logic vSync;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;
  modport master (output score, input hSync, vSync, VGA_R, VGA_G, VGA_B);
  modport slave (input score, output hSync, vSync, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480 raster counters with raw active and sync flags
module vga_timing
  import vga_score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hs_n,
  output logic       vs_n
);
  // pixel and line counters, line advances on pixel wrap
  always_ff @(posedge clk)
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= (hcount == H_TOT - 10'd1) ? '0 : hcount + 10'd1;
      if (hcount == H_TOT - 10'd1) vcount <= (vcount == V_TOT - 10'd1) ? '0 : vcount + 10'd1;
    end
  assign active = hcount < H_VIS && vcount < V_VIS;
  assign hs_n = !(hcount >= H_SYNC_START && hcount <= H_SYNC_END);
  assign vs_n = !(vcount >= V_SYNC_START && vcount <= V_SYNC_END);
endmodule

// File: rtl/vga_score_display.sv
// vga_score_display: draws the clamped score as two seven-segment digits
module vga_score_display
  import vga_score_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  vga_score_display_if.slave vga,
  inout  wire               ps2_clk,
  inout  wire               ps2_data
);
  logic [9:0] hcount, vcount;
  logic active, hs_n, vs_n;
  logic [6:0] score_q;
  logic [3:0] tens, ones;
  logic in_y, in_tens, in_ones, lit;
  logic [5:0] lx;
  logic [6:0] ly, segs, hit;
  vga_timing u_timing (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .active(active), .hs_n(hs_n), .vs_n(vs_n)
  );
  assign ps2_clk = 1'bz;
  assign ps2_data = 1'bz;
  // capture the clamped score once per frame so a frame never tears
  always_ff @(posedge clk)
    if (reset) score_q <= '0;
    else if (hcount == '0 && vcount == '0) score_q <= (vga.score > 32'd99) ? 7'd99 : vga.score[6:0];
  assign tens = tens_of(score_q);
  assign ones = 4'(score_q - 7'(tens) * 7'd10);
  assign in_y = vcount >= BOX_Y && vcount < BOX_Y + BOX_H;
  assign in_tens = in_y && hcount >= TENS_X && hcount < TENS_X + BOX_W;
  assign in_ones = in_y && hcount >= ONES_X && hcount < ONES_X + BOX_W;
  assign lx = 6'(hcount - (in_tens ? TENS_X : ONES_X));
  assign ly = 7'(vcount - BOX_Y);
  assign segs = in_tens ? SEG_MAP[tens] : in_ones ? SEG_MAP[ones] : '0;
  for (genvar s = 0; s < 7; s++) begin : g_seg
    assign hit[s] = segs[s]
      && 6'(lx - SEG_RECT[s].x0) <= 6'(SEG_RECT[s].x1 - SEG_RECT[s].x0)
      && 7'(ly - SEG_RECT[s].y0) <= 7'(SEG_RECT[s].y1 - SEG_RECT[s].y0);
  end
  assign lit = |hit;
  // one output stage keeps sync and colour aligned to the same pixel
  always_ff @(posedge clk)
    if (reset) {vga.hSync, vga.vSync, vga.VGA_R, vga.VGA_G, vga.VGA_B} <= {2'b11, 12'h000};
    else {vga.hSync, vga.vSync, vga.VGA_R, vga.VGA_G, vga.VGA_B} <= {hs_n, vs_n, active ? (lit ? FG : BG) : 12'h000};
endmodule

// File: tb/tb_vga_score_display.sv
// tb_vga_score_display: scoreboard bench for the score display
module tb_vga_score_display;
  logic clk = 1'b0;
  logic reset = 1'b1;
  wire ps2_clk, ps2_data;
  vga_score_display_if vga();
  vga_score_display dut (.clk(clk), .reset(reset), .vga(vga), .ps2_clk(ps2_clk), .ps2_data(ps2_data));
  always #20 clk = ~clk;
  typedef struct {
    string tag;
    int f;
    int h;
    int v;
    logic [13:0] exp;
  } ent_t;
  ent_t q[$];
  int errors = 0, checks = 0, cyc = 0, hs_low = 0, vs_low = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [13:0] outs();
    return {vga.hSync, vga.vSync, vga.VGA_R, vga.VGA_G, vga.VGA_B};
  endfunction
  task automatic push(input string tag, input int f, input int h, input int v, input logic [11:0] rgb);
    q.push_back('{tag, f, h, v, {(h >= 656 && h < 752) ? 1'b0 : 1'b1, (v == 490 || v == 491) ? 1'b0 : 1'b1, rgb}});
  endtask
  task automatic finish_up();
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask
  task automatic wait_at(input int f, input int h, input int v);
    int n = 0;
    while (!(cyc > 0 && (cyc - 1) / 420000 == f && (cyc - 1) % 800 == h && ((cyc - 1) / 800) % 525 == v)) begin
      @(negedge clk);
      n++;
      if (n > 450000) begin
        check("timeout", n, 0);
        finish_up();
      end
    end
  endtask
  // cycles since reset release; outputs at a negedge belong to pixel cyc-1
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  always @(negedge clk) if (cyc > 0) begin
    int p, f, h, v;
    p = cyc - 1;
    f = p / 420000;
    h = p % 800;
    v = (p / 800) % 525;
    if (f == 0) begin
      hs_low += int'(!vga.hSync);
      vs_low += int'(!vga.vSync);
    end
    if (q.size() > 0 && q[0].f == f && q[0].h == h && q[0].v == v) begin
      check(q[0].tag, 32'(outs()), 32'(q[0].exp));
      void'(q.pop_front());
    end
  end
  initial begin
    vga.score = 32'd7;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(outs()), 32'h3000);
    push("hs_pre", 0, 655, 0, 12'h000);
    push("hs_fall", 0, 656, 0, 12'h000);
    push("hs_last", 0, 751, 0, 12'h000);
    push("hs_rise", 0, 752, 0, 12'h000);
    push("hs_pre_l1", 0, 655, 1, 12'h000);
    push("hs_fall_l1", 0, 656, 1, 12'h000);
    push("blank_700_10", 0, 700, 10, 12'h000);
    push("corner_tl", 0, 336, 176, 12'h004);
    push("t0_a", 0, 280, 178, 12'hFFF);
    push("o7_a", 0, 360, 178, 12'hFFF);
    push("o7_a_ly7", 0, 360, 183, 12'hFFF);
    push("o7_ly8_gap", 0, 360, 184, 12'h004);
    push("left_of_box", 0, 255, 200, 12'h004);
    push("t0_b_edge", 0, 319, 200, 12'hFFF);
    push("o7_f", 0, 338, 200, 12'h004);
    push("o7_b", 0, 396, 200, 12'hFFF);
    push("right_of_box", 0, 400, 200, 12'h004);
    reset = 1'b0;
    wait_at(0, 0, 200);
    vga.score = 32'd123;
    push("t0_g", 0, 280, 240, 12'h004);
    push("o7_g_no_tear", 0, 360, 240, 12'h004);
    push("t0_e", 0, 258, 260, 12'hFFF);
    push("o7_e", 0, 338, 260, 12'h004);
    push("o7_c", 0, 396, 260, 12'hFFF);
    push("t0_d", 0, 280, 300, 12'hFFF);
    push("o7_d", 0, 360, 300, 12'h004);
    push("corner_br", 0, 399, 303, 12'h004);
    push("blank_v480", 0, 100, 480, 12'h000);
    push("vs_pre", 0, 799, 489, 12'h000);
    push("vs_fall", 0, 0, 490, 12'h000);
    push("vs_last", 0, 799, 491, 12'h000);
    push("vs_rise", 0, 0, 492, 12'h000);
    push("t9_a", 1, 280, 178, 12'hFFF);
    push("t9_g", 1, 280, 240, 12'hFFF);
    push("o9_g", 1, 360, 240, 12'hFFF);
    push("t9_e", 1, 258, 260, 12'h004);
    push("o9_e", 1, 338, 260, 12'h004);
    wait_at(1, 0, 100);
    check("hs_low_frame", hs_low, 525 * 96);
    check("vs_low_frame", vs_low, 1600);
    wait_at(1, 0, 270);
    vga.score = 32'd3;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mid", 32'(outs()), 32'h3000);
    push("rst_hs_fall", 0, 656, 0, 12'h000);
    push("r_t0_a", 0, 280, 178, 12'hFFF);
    push("o3_a", 0, 360, 178, 12'hFFF);
    push("o3_f", 0, 338, 200, 12'h004);
    push("o3_b", 0, 396, 200, 12'hFFF);
    reset = 1'b0;
    wait_at(0, 0, 200);
    vga.score = 32'd8;
    push("r_t0_g", 0, 280, 240, 12'h004);
    push("o3_g", 0, 360, 240, 12'hFFF);
    push("r_t0_e", 0, 258, 260, 12'hFFF);
    push("o3_e_no_tear", 0, 338, 260, 12'h004);
    push("o3_c", 0, 396, 260, 12'hFFF);
    push("o3_e_d_gap", 0, 338, 300, 12'h004);
    push("o3_d", 0, 360, 300, 12'hFFF);
    wait_at(0, 0, 310);
    finish_up();
  end
endmodule
